// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bundle: redirect input from the next-PC mux, instruction-memory
// req/gnt/rvalid channel and the valid/ready channel towards decode.
interface pc_fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign;

  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output pc, pc_plus4, imem_req, imem_addr, instr_valid, instr, instr_pc, misalign
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  pc, pc_plus4, imem_req, imem_addr, instr_valid, instr, instr_pc, misalign
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch sequencer with redirect/squash.
// Optional PC_ALIGN_CHECK_EN: misaligned redirects trap to EXC_VECTOR and pulse misalign.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, VALID, SQUASH} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] instr_pc_reg, instr_pc_next;
  logic        misalign_reg, misalign_next;
  logic [31:0] target;
  logic        target_bad;
  logic        take_redirect;

`ifdef PC_ALIGN_CHECK_EN
  assign target_bad = (bus.redirect_pc[1:0] != 2'b00);
  assign target     = target_bad ? EXC_VECTOR : bus.redirect_pc;
`else
  logic unused_cfg;
  assign target_bad = 1'b0;
  assign target     = {bus.redirect_pc[31:2], 2'b00};
  assign unused_cfg = ^{bus.redirect_pc[1:0], EXC_VECTOR};
`endif

  // IDLE only exists for the first cycle after reset and does not accept redirects.
  assign take_redirect = bus.redirect && (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      instr_reg    <= 32'h0;
      instr_pc_reg <= 32'h0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      misalign_reg <= misalign_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    misalign_next = 1'b0;
    case (state_reg)
      IDLE:   state_next = FETCH;
      FETCH: begin
        if (take_redirect)     state_next = bus.imem_gnt ? SQUASH : FETCH;
        else if (bus.imem_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (take_redirect) begin
          // A response arriving with the redirect is simply dropped.
          state_next = bus.imem_rvalid ? FETCH : SQUASH;
        end else if (bus.imem_rvalid) begin
          instr_next    = bus.imem_rdata;
          instr_pc_next = pc_reg;
          pc_next       = pc_reg + 32'd4;
          state_next    = VALID;
        end
      end
      VALID: begin
        if (take_redirect || bus.instr_ready) state_next = FETCH;
      end
      SQUASH: begin
        // Wait out the stale response so it is never mistaken for a new one.
        if (!take_redirect && bus.imem_rvalid) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
    if (take_redirect) begin
      pc_next       = target;
      misalign_next = target_bad;
    end
  end

  assign bus.pc          = pc_reg;
  assign bus.pc_plus4    = pc_reg + 32'd4;
  assign bus.imem_req    = (state_reg == FETCH);
  assign bus.imem_addr   = pc_reg;
  assign bus.instr_valid = (state_reg == VALID);
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;
  assign bus.misalign    = misalign_reg;

endmodule
